// File: rtl/hash_stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hash_stim_pkg
//  Description : Shared types, LFSR constants and the digest fold helper for
//                the streaming hash-core stimulus harness.
//  Contents    : stim_state_t   - harness FSM state encoding
//                LFSR_TAPS_64   - Galois taps, x^64+x^63+x^61+x^60+1
//                LFSR_TAPS_16   - Galois taps, x^16+x^14+x^13+x^11+1
//                LEN_SEED_XOR   - perturbation applied to SEED for the length LFSR
//                fold_xor()     - XOR of all sig_w-bit chunks of a digest
//  Revision    : 1.0  initial release
// ============================================================================
package hash_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } stim_state_t;

    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [63:0] LEN_SEED_XOR = 64'h0000_0000_0000_5A5A;

    // Upper bounds on the digest / signature widths fold_xor can handle.
    localparam int FOLD_MAX_IN  = 1024;
    localparam int FOLD_MAX_SIG = 64;
    localparam int FOLD_IN_IW   = $clog2(FOLD_MAX_IN);
    localparam int FOLD_SIG_IW  = $clog2(FOLD_MAX_SIG);

    // Bit i of the (zero-extended) digest lands on signature bit i % sig_w,
    // which is the same as XOR-ing every sig_w-bit chunk together as long as
    // the real digest width is a multiple of sig_w.
    function automatic logic [FOLD_MAX_SIG-1:0] fold_xor(
        input logic [FOLD_MAX_IN-1:0] data,
        input int                     sig_w
    );
        logic [FOLD_MAX_SIG-1:0] acc;
        acc = '0;
        for (int i = 0; i < FOLD_MAX_IN; i++) begin
            acc[FOLD_SIG_IW'(i % sig_w)] ^= data[FOLD_IN_IW'(i)];
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hash_stim_harness_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Right-shifting Galois LFSR that advances only when asked.
//  Ports       : clk   in  1      rising-edge clock
//                reset in  1      synchronous, active-high; reloads SEED
//                step  in  1      advance one position this cycle
//                value out WIDTH  current LFSR contents
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = '0,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/hash_stim_harness.sv
`default_nettype none
// ============================================================================
//  Module      : hash_stim_harness
//  Description : Self-stimulating harness for streaming hash cores. Builds
//                LFSR-driven messages of random length, honours the core's
//                buffer_full back-pressure, waits for each digest and folds
//                it into a small running signature.
//  Ports       : clk          in   1           rising-edge clock
//                reset        in   1           synchronous, active-high
//                enable       in   1           start/continue messages
//                core_in      out  DATA_W      data word to core
//                core_in_rdy  out  1           word valid
//                core_last    out  1           last word of message
//                core_bnum    out  BYTE_NUM_W  valid bytes in last word
//                core_full    in   1           core back-pressure
//                core_out     in   OUT_W       core digest
//                core_out_rdy in   1           digest valid (edge captured)
//                signature    out  SIG_W       running digest signature
//                msg_count    out  16          digests folded (wraps)
//                busy         out  1           FSM not idle
//                timeout_err  out  1           sticky digest timeout
//  Revision    : 1.0  initial release
// ============================================================================
module hash_stim_harness
    import hash_stim_pkg::*;
#(
    parameter int          DATA_W        = 64,
    parameter int          BYTE_NUM_W    = 3,
    parameter int          OUT_W         = 512,
    parameter int          SIG_W         = 16,
    parameter int          MAX_MSG_WORDS = 16,
    parameter int          TIMEOUT       = 4096,
    parameter logic [63:0] SEED          = 64'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [DATA_W-1:0]     core_in,
    output logic                  core_in_rdy,
    output logic                  core_last,
    output logic [BYTE_NUM_W-1:0] core_bnum,
    input  logic                  core_full,
    input  logic [OUT_W-1:0]      core_out,
    input  logic                  core_out_rdy,
    output logic [SIG_W-1:0]      signature,
    output logic [15:0]           msg_count,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int                 C_CNT_W   = (MAX_MSG_WORDS > 1) ? $clog2(MAX_MSG_WORDS) : 1;
    localparam int                 C_TO_W    = $clog2(TIMEOUT);
    localparam logic [C_TO_W-1:0]  C_TO_LAST = C_TO_W'(TIMEOUT - 1);
    localparam logic [15:0]        C_LEN_MSK = 16'(MAX_MSG_WORDS - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DATA_W != (8 << BYTE_NUM_W)) begin : g_chk_data_w
        $error("hash_stim_harness: DATA_W must equal 8 << BYTE_NUM_W");
    end
    if ((OUT_W % SIG_W) != 0) begin : g_chk_out_w
        $error("hash_stim_harness: OUT_W must be a multiple of SIG_W");
    end
    if (SEED == 64'd0) begin : g_chk_seed
        $error("hash_stim_harness: SEED must be nonzero");
    end
    if ((OUT_W > FOLD_MAX_IN) || (SIG_W > FOLD_MAX_SIG) || (SIG_W < 2)) begin : g_chk_fold
        $error("hash_stim_harness: OUT_W/SIG_W outside fold_xor range");
    end
    if ((TIMEOUT < 2) || ((MAX_MSG_WORDS & (MAX_MSG_WORDS - 1)) != 0)) begin : g_chk_misc
        $error("hash_stim_harness: TIMEOUT >= 2 and power-of-two MAX_MSG_WORDS required");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    stim_state_t            state_q,       state_d;
    logic [C_CNT_W-1:0]     last_idx_q,    last_idx_d;
    logic [C_CNT_W-1:0]     word_cnt_q,    word_cnt_d;
    logic [C_TO_W-1:0]      wait_cnt_q,    wait_cnt_d;
    logic                   out_rdy_q,     out_rdy_d;
    logic [DATA_W-1:0]      core_in_q,     core_in_d;
    logic                   core_in_rdy_q, core_in_rdy_d;
    logic                   core_last_q,   core_last_d;
    logic [BYTE_NUM_W-1:0]  core_bnum_q,   core_bnum_d;
    logic [SIG_W-1:0]       signature_q,   signature_d;
    logic [15:0]            msg_count_q,   msg_count_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [DATA_W-1:0]      w_data_word;
    logic [15:0]            w_len_word;
    logic                   w_data_step;
    logic                   w_len_step;
    logic                   w_capture;
    logic [SIG_W-1:0]       w_fold;

    // ------------------------------------------------------------------
    // Pattern sources
    // ------------------------------------------------------------------
    lfsr_gen #(
        .WIDTH (DATA_W),
        .TAPS  (DATA_W'(LFSR_TAPS_64)),
        .SEED  (DATA_W'(SEED))
    ) u_data_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (w_data_step),
        .value (w_data_word)
    );

    lfsr_gen #(
        .WIDTH (16),
        .TAPS  (LFSR_TAPS_16),
        .SEED  (16'(SEED ^ LEN_SEED_XOR))
    ) u_len_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (w_len_step),
        .value (w_len_word)
    );

    // Digest strobe is rising-edge detected so a core that holds out_ready
    // high for several cycles is folded only once.
    assign w_capture = core_out_rdy & ~out_rdy_q;
    assign w_fold    = SIG_W'(fold_xor(FOLD_MAX_IN'(core_out), SIG_W));
    assign out_rdy_d = core_out_rdy;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_idx_d    = last_idx_q;
        word_cnt_d    = word_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        core_in_d     = core_in_q;
        core_in_rdy_d = 1'b0;
        core_last_d   = 1'b0;
        core_bnum_d   = '0;
        signature_d   = signature_q;
        msg_count_d   = msg_count_q;
        timeout_err_d = timeout_err_q;
        w_data_step   = 1'b0;
        w_len_step    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                // Stored as L-1 so the counter never needs an extra bit.
                last_idx_d = C_CNT_W'(w_len_word & C_LEN_MSK);
                word_cnt_d = '0;
                w_len_step = 1'b1;
                state_d    = ST_SEND;
            end

            ST_SEND: begin
                // While the core is full nothing advances, so the same
                // LFSR word is offered again once it drains.
                if (!core_full) begin
                    core_in_rdy_d = 1'b1;
                    core_in_d     = w_data_word;
                    w_data_step   = 1'b1;
                    word_cnt_d    = word_cnt_q + 1'b1;
                    if (word_cnt_q == last_idx_q) begin
                        core_last_d = 1'b1;
                        core_bnum_d = w_data_word[BYTE_NUM_W-1:0];
                        wait_cnt_d  = '0;
                        state_d     = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Capture is tested first so it beats a same-cycle timeout.
                if (w_capture) begin
                    signature_d = {signature_q[SIG_W-2:0], signature_q[SIG_W-1]} ^ w_fold;
                    msg_count_d = msg_count_q + 16'd1;
                    state_d     = enable ? ST_LEN : ST_IDLE;
                end else if (wait_cnt_q == C_TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_idx_q    <= '0;
            word_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            out_rdy_q     <= 1'b0;
            core_in_q     <= '0;
            core_in_rdy_q <= 1'b0;
            core_last_q   <= 1'b0;
            core_bnum_q   <= '0;
            signature_q   <= '0;
            msg_count_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_idx_q    <= last_idx_d;
            word_cnt_q    <= word_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            out_rdy_q     <= out_rdy_d;
            core_in_q     <= core_in_d;
            core_in_rdy_q <= core_in_rdy_d;
            core_last_q   <= core_last_d;
            core_bnum_q   <= core_bnum_d;
            signature_q   <= signature_d;
            msg_count_q   <= msg_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign core_in     = core_in_q;
    assign core_in_rdy = core_in_rdy_q;
    assign core_last   = core_last_q;
    assign core_bnum   = core_bnum_q;
    assign signature   = signature_q;
    assign msg_count   = msg_count_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_stim_harness.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hash_stim_harness
//  Description : Scoreboard bench for hash_stim_harness. Expected message
//                words are queued when a message is triggered and checked as
//                the harness emits them; digests are folded by a local model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hash_stim_harness;

    localparam int          DATA_W        = 64;
    localparam int          BYTE_NUM_W    = 3;
    localparam int          OUT_W         = 512;
    localparam int          SIG_W         = 16;
    localparam int          MAX_MSG_WORDS = 8;
    localparam int          TIMEOUT       = 32;
    localparam logic [63:0] SEED          = 64'hACE1;
    // 16'hACE1 ^ 16'h5A5A
    localparam logic [15:0] LEN_SEED      = 16'hF6BB;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [DATA_W-1:0]     core_in;
    logic                  core_in_rdy;
    logic                  core_last;
    logic [BYTE_NUM_W-1:0] core_bnum;
    logic                  core_full;
    logic [OUT_W-1:0]      core_out;
    logic                  core_out_rdy;
    logic [SIG_W-1:0]      signature;
    logic [15:0]           msg_count;
    logic                  busy;
    logic                  timeout_err;

    hash_stim_harness #(
        .DATA_W        (DATA_W),
        .BYTE_NUM_W    (BYTE_NUM_W),
        .OUT_W         (OUT_W),
        .SIG_W         (SIG_W),
        .MAX_MSG_WORDS (MAX_MSG_WORDS),
        .TIMEOUT       (TIMEOUT),
        .SEED          (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .core_in      (core_in),
        .core_in_rdy  (core_in_rdy),
        .core_last    (core_last),
        .core_bnum    (core_bnum),
        .core_full    (core_full),
        .core_out     (core_out),
        .core_out_rdy (core_out_rdy),
        .signature    (signature),
        .msg_count    (msg_count),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [2:0]  bnum;
    } word_t;

    word_t       exp_q[$];
    word_t       mon_w;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] m_data;
    logic [15:0] m_len;
    logic [15:0] m_sig;
    logic [15:0] m_cnt;
    int          cur_words = 0;
    int          cur_len   = 0;
    bit          last_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // x^64+x^63+x^61+x^60+1, right-shifting Galois form
    function automatic logic [63:0] nxt64(input logic [63:0] v);
        return v[0] ? ((v >> 1) ^ 64'hD800_0000_0000_0000) : (v >> 1);
    endfunction

    // x^16+x^14+x^13+x^11+1, right-shifting Galois form
    function automatic logic [15:0] nxt16(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] fold16(input logic [OUT_W-1:0] d);
        logic [15:0] f;
        f = '0;
        for (int i = 0; i < OUT_W / 16; i++) f ^= d[16*i +: 16];
        return f;
    endfunction

    function automatic logic [OUT_W-1:0] rand_digest();
        logic [OUT_W-1:0] r;
        for (int i = 0; i < OUT_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_data = SEED;
        m_len  = LEN_SEED;
        m_sig  = '0;
        m_cnt  = '0;
        exp_q.delete();
    endtask

    // Queue every word of the message the harness is about to generate.
    task automatic push_msg();
        word_t w;
        int    len;
        len       = int'(m_len & 16'(MAX_MSG_WORDS - 1)) + 1;
        m_len     = nxt16(m_len);
        cur_len   = len;
        cur_words = 0;
        last_seen = 1'b0;
        for (int k = 0; k < len; k++) begin
            w.data = m_data;
            w.last = (k == len - 1);
            w.bnum = w.last ? m_data[2:0] : 3'd0;
            exp_q.push_back(w);
            m_data = nxt64(m_data);
        end
    endtask

    task automatic wait_first();
        for (int i = 0; i < 200 && cur_words == 0; i++) tick();
        chk("wait_first", 64'(cur_words > 0), 64'd1);
    endtask

    task automatic wait_last();
        for (int i = 0; i < 200 && !last_seen; i++) tick();
        chk("wait_last", 64'(last_seen), 64'd1);
        chk("word_total", 64'(cur_words), 64'(cur_len));
    endtask

    // One-cycle digest strobe; checks the fold on the following cycle.
    task automatic pulse_digest(input logic [OUT_W-1:0] d);
        core_out     = d;
        core_out_rdy = 1'b1;
        m_sig        = {m_sig[14:0], m_sig[15]} ^ fold16(d);
        m_cnt        = m_cnt + 16'd1;
        tick();
        core_out_rdy = 1'b0;
        chk("signature", 64'(signature), 64'(m_sig));
        chk("msg_count", 64'(msg_count), 64'(m_cnt));
    endtask

    // Word monitor / scoreboard consumer
    always @(negedge clk) begin
        if (core_in_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(core_in_rdy), 64'd0);
            end else begin
                mon_w = exp_q.pop_front();
                chk("core_in", core_in, mon_w.data);
                chk("core_last", 64'(core_last), 64'(mon_w.last));
                chk("core_bnum", 64'(core_bnum), 64'(mon_w.bnum));
                cur_words++;
                if (core_last === 1'b1) last_seen = 1'b1;
            end
        end else begin
            chk("idle_last_bnum", 64'({core_last, core_bnum}), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        core_full    = 1'b0;
        core_out     = '0;
        core_out_rdy = 1'b0;
        model_reset();

        // Reset held 3 cycles with enable high
        repeat (3) @(posedge clk);
        tick();
        chk("rst_core_in",     core_in,              64'd0);
        chk("rst_core_in_rdy", 64'(core_in_rdy),     64'd0);
        chk("rst_signature",   64'(signature),       64'd0);
        chk("rst_msg_count",   64'(msg_count),       64'd0);
        chk("rst_busy",        64'(busy),            64'd0);
        chk("rst_timeout_err", 64'(timeout_err),     64'd0);

        // Message 1; digest folds to zero
        reset = 1'b0;
        push_msg();
        wait_last();
        chk("busy_in_wait", 64'(busy), 64'd1);
        push_msg();
        pulse_digest({32{16'h0001}});
        chk("sig_zero", 64'(signature), 64'd0);

        // Message 2 with 5 cycles of back-pressure after the first word
        wait_first();
        if (cur_len >= 2 && !last_seen) begin
            core_full = 1'b1;
            repeat (5) begin
                tick();
                chk("bp_rdy_low", 64'(core_in_rdy), 64'd0);
            end
            core_full = 1'b0;
        end
        wait_last();
        push_msg();
        pulse_digest(OUT_W'(16'h00FF));
        chk("sig_00ff", 64'(signature), 64'h00FF);
        chk("count_two", 64'(msg_count), 64'd2);

        // Message 3: enable dropped mid-message
        wait_first();
        enable = 1'b0;
        wait_last();
        chk("stop_busy_before_fold", 64'(busy), 64'd1);
        pulse_digest(rand_digest());
        chk("stop_busy_after_fold", 64'(busy), 64'd0);
        repeat (10) tick();
        chk("stop_parked", 64'(busy), 64'd0);

        // Message 4: digest never arrives
        enable = 1'b1;
        push_msg();
        wait_last();
        enable = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("to_not_yet", 64'(timeout_err), 64'd0);
        chk("to_busy_pre", 64'(busy), 64'd1);
        tick();
        chk("to_err_set", 64'(timeout_err), 64'd1);
        chk("to_idle", 64'(busy), 64'd0);
        chk("to_count_kept", 64'(msg_count), 64'(m_cnt));
        chk("to_sig_kept", 64'(signature), 64'(m_sig));
        repeat (3) tick();
        chk("to_sticky", 64'(timeout_err), 64'd1);

        // Edge arrives in the very cycle the timeout would fire
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        chk("rst_clears_err", 64'(timeout_err), 64'd0);
        enable = 1'b1;
        push_msg();
        wait_last();
        enable = 1'b0;
        repeat (TIMEOUT - 1) tick();
        pulse_digest(rand_digest());
        chk("coin_no_err", 64'(timeout_err), 64'd0);
        chk("coin_idle", 64'(busy), 64'd0);

        // Reset in the middle of SEND
        enable = 1'b1;
        push_msg();
        wait_first();
        reset = 1'b1;
        tick();
        chk("midrst_rdy", 64'(core_in_rdy), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sig", 64'(signature), 64'd0);
        chk("midrst_count", 64'(msg_count), 64'd0);
        model_reset();
        reset = 1'b0;
        push_msg();
        wait_last();
        enable = 1'b0;
        pulse_digest(rand_digest());
        chk("final_idle", 64'(busy), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
